neuron_stream: RTL and testbench

Parametrised successor to the fixed 32-bit neuron. One neuron of the MNIST accelerator's dense layers. It accepts a stream of FAN_IN signed fixed-point (weight, activation) pairs over a valid/ready handshake and accumulates their products at full precision. It then adds the bias, rescales, saturates and applies ReLU, and holds one result on an output handshake until the layer node consumes it.

---
 rtl/neuron_stream.sv | 179 +++++++++++++++++
 tb/tb_neuron_stream.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/neuron_stream.sv
// neuron_stream: one dense-layer neuron for the MNIST accelerator.
//
// This block streams FAN_IN signed fixed-point (weight, activation) pairs over a
// valid/ready handshake. It accumulates their products at full precision, adds the
// bias and rescales by FRAC_W. It then saturates to DATA_W, optionally applies ReLU,
// and holds the result on an output valid/ready handshake.
//
// Build option:
//   NEURON_RELU_EN  defined   -> out_data = max(0, r_sat)  (hidden layers)
//                   undefined -> out_data = r_sat           (output-layer logits)
//
// Parameters:
//   DATA_W  width of weight, activation, bias and result (signed)
//   FRAC_W  fractional bits of the Q format (FRAC_W < DATA_W)
//   FAN_IN  pairs per dot product (>= 1)
//
// Ports:
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   input pair valid
//   in_ready   neuron accepts a pair this cycle (IDLE or ACC)
//   in_head    first pair of a dot product, qualified by the accepted beat
//   in_w       weight
//   in_x       activation
//   in_b       bias, sampled on the head beat only
//   out_valid  out_data holds a result
//   out_ready  consumer takes the result
//   out_data   saturated, post-activation result
//   err        one-cycle pulse after a framing error
module neuron_stream #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned FAN_IN = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_head,
  input  logic signed [DATA_W-1:0] in_w,
  input  logic signed [DATA_W-1:0] in_x,
  input  logic signed [DATA_W-1:0] in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [DATA_W-1:0] out_data,
  output logic                     err
);

  localparam int unsigned ACC_W  = 2 * DATA_W + $clog2(FAN_IN) + 1;
  localparam int unsigned CNT_W  = $clog2(FAN_IN + 1);
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned TOP_W  = ACC_W - DATA_W + 1;

  localparam logic [CNT_W-1:0] CntFull = CNT_W'(FAN_IN);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StFin,
    StOut
  } state_e;

  state_e                     state_q, state_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [DATA_W-1:0]   bias_q, bias_d;
  logic        [CNT_W-1:0]    cnt_q, cnt_d;
  logic        [DATA_W-1:0]   out_data_q, out_data_d;
  logic                       err_q, err_d;

  logic                       beat;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    bias_ext;
  logic signed [ACC_W-1:0]    sum;
  logic signed [ACC_W-1:0]    r;
  logic        [TOP_W-1:0]    r_top;
  logic                       r_ovf;
  logic        [DATA_W-1:0]   r_sat;
  logic        [DATA_W-1:0]   act;

  assign in_ready  = (state_q == StIdle) || (state_q == StAcc);
  assign out_valid = (state_q == StOut);
  assign out_data  = out_data_q;
  assign err       = err_q;

  assign beat = in_valid && in_ready;

  // Full-precision signed product, sign-extended into the accumulator width.
  assign prod     = in_w * in_x;
  assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

  // Align the bias with the product's 2*FRAC_W fractional bits, then drop FRAC_W
  // of them. The arithmetic shift makes the truncation round toward minus infinity.
  assign bias_ext = {{(ACC_W - DATA_W){bias_q[DATA_W-1]}}, bias_q} <<< FRAC_W;
  assign sum      = acc_q + bias_ext;
  assign r        = sum >>> FRAC_W;

  // r fits in DATA_W only when every bit from the DATA_W-1 sign position upward agrees.
  assign r_top = r[ACC_W-1:DATA_W-1];
  assign r_ovf = !((&r_top) || !(|r_top));

  always_comb begin
    r_sat = r[DATA_W-1:0];
    if (r_ovf) begin
      r_sat = r[ACC_W-1] ? {1'b1, {(DATA_W - 1){1'b0}}} : {1'b0, {(DATA_W - 1){1'b1}}};
    end
  end

`ifdef NEURON_RELU_EN
  assign act = r_sat[DATA_W-1] ? '0 : r_sat;
`else
  assign act = r_sat;
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    bias_d     = bias_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    err_d      = 1'b0;

    unique case (state_q)
      StIdle, StAcc: begin
        if (beat) begin
          if (in_head) begin
            // A head beat always starts a fresh dot product. A head seen in ACC
            // abandons the partial frame and is flagged.
            acc_d   = prod_ext;
            bias_d  = in_b;
            cnt_d   = CntOne;
            err_d   = (state_q == StAcc);
            state_d = (CntOne == CntFull) ? StFin : StAcc;
          end else if (state_q == StIdle) begin
            // A non-head beat with no frame open is swallowed.
            err_d = 1'b1;
          end else begin
            acc_d   = acc_q + prod_ext;
            cnt_d   = cnt_q + CntOne;
            state_d = (cnt_d == CntFull) ? StFin : StAcc;
          end
        end
      end
      StFin: begin
        out_data_d = act;
        state_d    = StOut;
      end
      StOut: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      bias_q     <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      bias_q     <= bias_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_neuron_stream.sv
// Directed bench for neuron_stream (DATA_W=16, FRAC_W=8, FAN_IN=4).
// Expected values are hand-computed. Build-dependent results go through act_exp().
module tb_neuron_stream;

`ifdef NEURON_RELU_EN
  localparam bit ReluEn = 1'b1;
`else
  localparam bit ReluEn = 1'b0;
`endif

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_head;
  logic [15:0] in_w;
  logic [15:0] in_x;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        err;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  neuron_stream #(
    .DATA_W(16),
    .FRAC_W(8),
    .FAN_IN(4)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_head  (in_head),
    .in_w     (in_w),
    .in_x     (in_x),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .err      (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] act_exp(input logic [15:0] v);
    return (ReluEn && v[15]) ? 16'h0000 : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one beat at a negedge. It is accepted at the following posedge.
  // The registered err is then checked one negedge later.
  task automatic send(input logic h, input logic [15:0] w, input logic [15:0] x,
                      input logic [15:0] b, input logic exp_err, input string tag);
    in_valid = 1'b1;
    in_head  = h;
    in_w     = w;
    in_x     = x;
    in_b     = b;
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clock);
    in_valid = 1'b0;
    in_head  = 1'b0;
    check({tag, " err"}, 32'(err), 32'(exp_err));
  endtask

  // Four-beat frame with a constant pair. This returns at the first cycle of OUT.
  task automatic run_frame(input logic [15:0] w, input logic [15:0] x, input logic [15:0] b,
                           input logic [15:0] exp, input string tag);
    send(1'b1, w, x, b, 1'b0, {tag, " b1"});
    send(1'b0, w, x, b, 1'b0, {tag, " b2"});
    send(1'b0, w, x, b, 1'b0, {tag, " b3"});
    send(1'b0, w, x, b, 1'b0, {tag, " b4"});
    check({tag, " fin out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " fin in_ready"}, 32'(in_ready), 32'd0);
    @(negedge clock);
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check({tag, " out_data"}, 32'(out_data), 32'(exp));
  endtask

  // With out_ready high, the OUT cycle is the handshake.
  task automatic finish_hs(input string tag);
    @(negedge clock);
    check({tag, " hs out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " hs in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_head   = 1'b0;
    in_w      = '0;
    in_x      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clock);

    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;
    @(negedge clock);

    // 4 * (256*512) = 524288, + 256<<8 = 589824, >>8 = 2304
    run_frame(16'd256, 16'd512, 16'd256, 16'd2304, "basic");
    finish_hs("basic");

    // 4 * (256*-256) = -262144, >>8 = -1024
    run_frame(16'd256, 16'hFF00, 16'd0, act_exp(16'hFC00), "neg");
    finish_hs("neg");

    // -4 >>> 8 = -1: the result rounds toward minus infinity, not zero
    run_frame(16'd1, 16'hFFFF, 16'd0, act_exp(16'hFFFF), "floor_neg");
    finish_hs("floor_neg");

    // 4 >>> 8 = 0
    run_frame(16'd1, 16'd1, 16'd0, 16'd0, "floor_pos");
    finish_hs("floor_pos");

    run_frame(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, "sat_pos");
    finish_hs("sat_pos");

    run_frame(16'h7FFF, 16'h8000, 16'h7FFF, act_exp(16'h8000), "sat_neg");
    finish_hs("sat_neg");

    // (-32768)^2 * 4 = 2^32 requires the accumulator's headroom
    run_frame(16'h8000, 16'h8000, 16'h8000, 16'h7FFF, "sat_max_prod");
    finish_hs("sat_max_prod");

    // Backpressure: the result holds for 5 cycles while stray input is ignored.
    out_ready = 1'b0;
    run_frame(16'd256, 16'd256, 16'd0, 16'd1024, "stall");
    in_valid = 1'b1;
    in_head  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("stall out_valid", 32'(out_valid), 32'd1);
      check("stall out_data", 32'(out_data), 32'd1024);
      check("stall in_ready", 32'(in_ready), 32'd0);
      check("stall err", 32'(err), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    finish_hs("stall");

    // A non-head beat in IDLE pulses err for exactly one cycle and produces no result.
    send(1'b0, 16'd256, 16'd256, 16'd0, 1'b1, "orphan");
    @(negedge clock);
    check("orphan err clears", 32'(err), 32'd0);
    check("orphan no result", 32'(out_valid), 32'd0);
    check("orphan in_ready", 32'(in_ready), 32'd1);

    // A head beat mid-frame restarts the sum with the new bias: 4*65536>>8 + 512 = 1536.
    send(1'b1, 16'd256, 16'd256, 16'd100, 1'b0, "rehead b1");
    send(1'b0, 16'd256, 16'd256, 16'd100, 1'b0, "rehead b2");
    send(1'b1, 16'd256, 16'd256, 16'd512, 1'b1, "rehead b3");
    send(1'b0, 16'd256, 16'd256, 16'd0, 1'b0, "rehead b4");
    send(1'b0, 16'd256, 16'd256, 16'd0, 1'b0, "rehead b5");
    check("rehead not done", 32'(out_valid), 32'd0);
    send(1'b0, 16'd256, 16'd256, 16'd0, 1'b0, "rehead b6");
    check("rehead fin", 32'(out_valid), 32'd0);
    @(negedge clock);
    check("rehead out_valid", 32'(out_valid), 32'd1);
    check("rehead out_data", 32'(out_data), 32'd1536);
    finish_hs("rehead");

    // A reset mid-frame discards the partial sum. The next beat must carry a head.
    send(1'b1, 16'd256, 16'd512, 16'd256, 1'b0, "abort b1");
    send(1'b0, 16'd256, 16'd512, 16'd256, 1'b0, "abort b2");
    reset_n = 1'b0;
    #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort out_data", 32'(out_data), 32'd0);
    check("abort err", 32'(err), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    send(1'b0, 16'd256, 16'd512, 16'd0, 1'b1, "post reset orphan");
    run_frame(16'd256, 16'd256, 16'd0, 16'd1024, "post reset");
    finish_hs("post reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
